gem_ext_fifo_tx_sf: RTL and testbench
=====================================

// Module: gem_ext_fifo_tx_sf
// PURPOSE
//  Parametrised store-and-forward GEM external-FIFO TX bridge; integrates the frame buffer so no external axis_fifo is needed.
//  Accepts 8-bit AXI-Stream frames, commits whole frames to internal RAM, and serves the ZynqMP GEM TX FIFO read interface.
//  Adds optional bad-frame drop, overflow drop and TX-status/end-toggle handshake. Sits between the packet source and the PS GEM.
// PARAMETERS
//  ADDR_WIDTH       11  RAM depth = 2**ADDR_WIDTH bytes; each entry holds {user,last,data[7:0]}
//  FRAME_CNT_WIDTH   6  committed-frame counter width; max 2**FRAME_CNT_WIDTH-1 stored frames
//  DROP_BAD_FRAME    1  1: discard frame with tuser=1 at tlast; 0: forward it with gem_err on eop
//  STAT_WIDTH       32  statistics counter width (GEM_TX_STATS_EN only)
// PORTS
//  clk                    in   1   single clock (AXIS and GEM side)
//  rst                    in   1   synchronous reset, active-high
//  s_axis_tdata           in   8   frame byte
//  s_axis_tvalid          in   1   byte valid
//  s_axis_tlast           in   1   last byte of frame
//  s_axis_tuser           in   1   bad-frame flag, sampled with tlast
//  s_axis_tready          out  1   = ~frame_cnt_full
//  gem_data               out  8   byte to GEM
//  gem_data_ready         out  1   >=1 committed frame available
//  gem_data_valid         out  1   gem_data valid (1 cycle after request)
//  gem_data_rd_request    in   1   GEM requests one byte
//  gem_sop / gem_eop      out  1   first / last byte of frame, qualified by valid
//  gem_err                out  1   frame error, with eop byte
//  gem_underflow          out  1   request served with no data
//  gem_control            out  1   constant 0
//  gem_dma_tx_end_tog     in   1   GEM toggles when a frame finishes
//  gem_status             in   4   GEM TX status, valid at end_tog edge
//  gem_dma_tx_status_tog  out  1   toggled 1 cycle after end_tog edge (status consumed)
//  tx_status              out  4   last captured gem_status
//  stat_tx_frames / stat_drop_frames / stat_tx_err  out STAT_WIDTH  counters
// BEHAVIOUR
//  Reset: all outputs 0, pointers/counters 0, s_axis_tready=1; partial frames in write or read discarded.
//  Write: byte accepted when tvalid&tready; wr_ptr advances, commit_ptr fixed until tlast.
//   tlast & ~(tuser&DROP_BAD_FRAME): commit_ptr<=wr_ptr+1, frame_cnt++; bad frame: wr_ptr<=commit_ptr, drop++.
//   RAM full mid-frame (wr_ptr+1==rd_ptr): frame dropped, wr_ptr<=commit_ptr, bytes discarded (tready stays 1) to tlast, drop++.
//   Frame larger than 2**ADDR_WIDTH-1 always takes the overflow drop path.
//  Read: gem_data_ready = (frame_cnt!=0). rd_request at cycle N -> data/valid/sop/eop/err at N+1, one byte per request.
//   sop on first byte after reset or previous eop; eop on stored last bit; at eop frame_cnt--.
//   err = stored user bit at eop (only possible when DROP_BAD_FRAME=0).
//   rd_request with frame_cnt==0 -> valid=1, underflow=1, data=0, pointers unchanged.
//  Commit and eop in same cycle: frame_cnt unchanged (+1-1); ready stays correct, no glitch.
//  Pointer wrap: ADDR_WIDTH-bit modulo; full = wr_ptr+1==rd_ptr (one entry reserved).
//  Status: end_tog double-edge detect; on edge tx_status<=gem_status, status_tog toggles next cycle.
//  frame_cnt saturated: tready=0 until an eop frees a slot.
// CONFIGURATION
//  GEM_TX_STATS_EN defined: stat_tx_frames ++ per eop, stat_drop_frames ++ per drop, stat_tx_err ++ per end_tog edge with
//   gem_status!=0; all wrap at 2**STAT_WIDTH, cleared by rst.
//  Undefined: counters not built, stat_* ports tied to 0.
// TESTING
//  64-byte frame 0x00..0x3F, tuser=0 -> ready after tlast; 64 requests give 0x00..0x3F, sop byte0, eop byte63, err=0.
//  Frame with tuser=1, DROP_BAD_FRAME=1 -> gem_data_ready stays 0, stat_drop_frames=1; next good frame read intact.
//  ADDR_WIDTH=6, send 70-byte frame -> dropped, stat_drop_frames=1; following 10-byte frame delivered correctly.
//  rd_request with empty buffer -> next cycle valid=1, underflow=1, data=0x00.
//  Toggle gem_dma_tx_end_tog with gem_status=4'h2 -> tx_status=4'h2, status_tog flips 1 cycle later, stat_tx_err=1.
//  Assert rst mid-read of 3-frame backlog -> ready=0, next frame after reset starts with sop, no stale bytes.

Source files
------------

// File: rtl/gem_ext_fifo_tx_sf.sv
// Store-and-forward bridge from an 8-bit AXI-Stream source to the ZynqMP GEM external TX FIFO interface.
// Define GEM_TX_STATS_EN to build the statistics counters; otherwise the stat_* ports are tied to zero.
module gem_ext_fifo_tx_sf #(
    parameter int ADDR_WIDTH      = 11,
    parameter int FRAME_CNT_WIDTH = 6,
    parameter int DROP_BAD_FRAME  = 1,
    parameter int STAT_WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tuser,
    output logic                  s_axis_tready,
    output logic [7:0]            gem_data,
    output logic                  gem_data_ready,
    output logic                  gem_data_valid,
    input  logic                  gem_data_rd_request,
    output logic                  gem_sop,
    output logic                  gem_eop,
    output logic                  gem_err,
    output logic                  gem_underflow,
    output logic                  gem_control,
    input  logic                  gem_dma_tx_end_tog,
    input  logic [3:0]            gem_status,
    output logic                  gem_dma_tx_status_tog,
    output logic [3:0]            tx_status,
    output logic [STAT_WIDTH-1:0] stat_tx_frames,
    output logic [STAT_WIDTH-1:0] stat_drop_frames,
    output logic [STAT_WIDTH-1:0] stat_tx_err
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Each entry is {user, last, data}
    logic [9:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0]      wr_ptr_reg, wr_ptr_next;
    logic [ADDR_WIDTH-1:0]      commit_ptr_reg, commit_ptr_next;
    logic [ADDR_WIDTH-1:0]      rd_ptr_reg;
    logic [ADDR_WIDTH-1:0]      wr_ptr_inc;
    logic                       dropping_reg, dropping_next;
    logic [FRAME_CNT_WIDTH-1:0] frame_cnt_reg, frame_cnt_next;

    logic       accept, ram_full, bad_frame, mem_we, commit, drop;
    logic       serve, eop_now;
    logic [9:0] rd_word_reg;
    logic       out_valid_reg, underflow_reg, sop_reg, sop_pending_reg;

    logic       end_tog_reg, status_ack_reg, status_tog_reg, status_edge;
    logic [3:0] tx_status_reg;

    assign s_axis_tready = ~(&frame_cnt_reg);
    assign accept        = s_axis_tvalid & s_axis_tready;
    assign wr_ptr_inc    = wr_ptr_reg + ADDR_WIDTH'(1);
    assign ram_full      = (wr_ptr_inc == rd_ptr_reg);
    assign bad_frame     = s_axis_tuser & (DROP_BAD_FRAME != 0);

    // Once a frame overflows, the rest of it is swallowed up to tlast so the source never stalls
    always_comb begin
        wr_ptr_next     = wr_ptr_reg;
        commit_ptr_next = commit_ptr_reg;
        dropping_next   = dropping_reg;
        mem_we          = 1'b0;
        commit          = 1'b0;
        drop            = 1'b0;
        if (accept) begin
            if (dropping_reg) begin
                if (s_axis_tlast) dropping_next = 1'b0;
            end else if (ram_full) begin
                wr_ptr_next   = commit_ptr_reg;
                drop          = 1'b1;
                dropping_next = ~s_axis_tlast;
            end else begin
                mem_we = 1'b1;
                if (s_axis_tlast) begin
                    if (bad_frame) begin
                        wr_ptr_next = commit_ptr_reg;
                        drop        = 1'b1;
                    end else begin
                        wr_ptr_next     = wr_ptr_inc;
                        commit_ptr_next = wr_ptr_inc;
                        commit          = 1'b1;
                    end
                end else begin
                    wr_ptr_next = wr_ptr_inc;
                end
            end
        end
    end

    assign eop_now = out_valid_reg & ~underflow_reg & rd_word_reg[8];

    // A frame whose eop is on the output this cycle no longer counts as readable
    assign serve = gem_data_rd_request & (frame_cnt_reg != '0) &
                   ~(eop_now & (frame_cnt_reg == FRAME_CNT_WIDTH'(1)));

    always_comb begin
        frame_cnt_next = frame_cnt_reg;
        case ({commit, eop_now})
            2'b10:   frame_cnt_next = frame_cnt_reg + FRAME_CNT_WIDTH'(1);
            2'b01:   frame_cnt_next = frame_cnt_reg - FRAME_CNT_WIDTH'(1);
            default: frame_cnt_next = frame_cnt_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_ptr_reg] <= {s_axis_tuser, s_axis_tlast, s_axis_tdata};
        if (serve)  rd_word_reg     <= mem[rd_ptr_reg];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg      <= '0;
            commit_ptr_reg  <= '0;
            rd_ptr_reg      <= '0;
            dropping_reg    <= 1'b0;
            frame_cnt_reg   <= '0;
            out_valid_reg   <= 1'b0;
            underflow_reg   <= 1'b0;
            sop_reg         <= 1'b0;
            sop_pending_reg <= 1'b1;
        end else begin
            wr_ptr_reg     <= wr_ptr_next;
            commit_ptr_reg <= commit_ptr_next;
            dropping_reg   <= dropping_next;
            frame_cnt_reg  <= frame_cnt_next;
            out_valid_reg  <= gem_data_rd_request;
            underflow_reg  <= gem_data_rd_request & ~serve;
            sop_reg        <= serve & (sop_pending_reg | eop_now);
            if (serve) begin
                rd_ptr_reg      <= rd_ptr_reg + ADDR_WIDTH'(1);
                sop_pending_reg <= 1'b0;
            end else if (eop_now) begin
                sop_pending_reg <= 1'b1;
            end
        end
    end

    assign gem_data_ready = (frame_cnt_reg != '0);
    assign gem_data_valid = out_valid_reg;
    assign gem_data       = (out_valid_reg & ~underflow_reg) ? rd_word_reg[7:0] : 8'h00;
    assign gem_sop        = sop_reg;
    assign gem_eop        = eop_now;
    assign gem_err        = eop_now & rd_word_reg[9];
    assign gem_underflow  = underflow_reg;
    assign gem_control    = 1'b0;

    // Status handshake: capture on either edge of end_tog, acknowledge one cycle later
    assign status_edge = gem_dma_tx_end_tog ^ end_tog_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            end_tog_reg    <= 1'b0;
            status_ack_reg <= 1'b0;
            status_tog_reg <= 1'b0;
            tx_status_reg  <= 4'h0;
        end else begin
            end_tog_reg    <= gem_dma_tx_end_tog;
            status_ack_reg <= status_edge;
            if (status_edge)    tx_status_reg  <= gem_status;
            if (status_ack_reg) status_tog_reg <= ~status_tog_reg;
        end
    end

    assign gem_dma_tx_status_tog = status_tog_reg;
    assign tx_status             = tx_status_reg;

`ifdef GEM_TX_STATS_EN
    logic [STAT_WIDTH-1:0] stat_tx_frames_reg, stat_drop_frames_reg, stat_tx_err_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_tx_frames_reg   <= '0;
            stat_drop_frames_reg <= '0;
            stat_tx_err_reg      <= '0;
        end else begin
            if (eop_now) stat_tx_frames_reg   <= stat_tx_frames_reg + STAT_WIDTH'(1);
            if (drop)    stat_drop_frames_reg <= stat_drop_frames_reg + STAT_WIDTH'(1);
            if (status_edge && (gem_status != 4'h0))
                stat_tx_err_reg <= stat_tx_err_reg + STAT_WIDTH'(1);
        end
    end

    assign stat_tx_frames   = stat_tx_frames_reg;
    assign stat_drop_frames = stat_drop_frames_reg;
    assign stat_tx_err      = stat_tx_err_reg;
`else
    assign stat_tx_frames   = '0;
    assign stat_drop_frames = '0;
    assign stat_tx_err      = '0;
`endif

endmodule

// File: tb/tb_gem_ext_fifo_tx_sf.sv
// Directed bench for gem_ext_fifo_tx_sf: a default instance and a small (64-entry, bad-frame-forwarding)
// instance share stimulus; sel routes handshakes and observed outputs to one of them.
module tb_gem_ext_fifo_tx_sf;

    logic       clk = 1'b0;
    logic       rst, sel;
    logic [7:0] tdata;
    logic       tvalid, tlast, tuser, rd_req, end_tog;
    logic [3:0] status;

    logic        a_tready, a_ready, a_valid, a_sop, a_eop, a_err, a_uf, a_ctrl, a_stog;
    logic [7:0]  a_data;
    logic [3:0]  a_txs;
    logic [31:0] a_sf, a_sd, a_se;
    logic        b_tready, b_ready, b_valid, b_sop, b_eop, b_err, b_uf, b_ctrl, b_stog;
    logic [7:0]  b_data;
    logic [3:0]  b_txs;
    logic [31:0] b_sf, b_sd, b_se;

    logic        o_tready, o_ready, o_valid, o_sop, o_eop, o_err, o_uf, o_ctrl, o_stog;
    logic [7:0]  o_data;
    logic [3:0]  o_txs;
    logic [31:0] o_sf, o_sd, o_se;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    gem_ext_fifo_tx_sf dut_a (
        .clk(clk), .rst(rst),
        .s_axis_tdata(tdata), .s_axis_tvalid(tvalid & ~sel), .s_axis_tlast(tlast),
        .s_axis_tuser(tuser), .s_axis_tready(a_tready),
        .gem_data(a_data), .gem_data_ready(a_ready), .gem_data_valid(a_valid),
        .gem_data_rd_request(rd_req & ~sel), .gem_sop(a_sop), .gem_eop(a_eop), .gem_err(a_err),
        .gem_underflow(a_uf), .gem_control(a_ctrl), .gem_dma_tx_end_tog(end_tog),
        .gem_status(status), .gem_dma_tx_status_tog(a_stog), .tx_status(a_txs),
        .stat_tx_frames(a_sf), .stat_drop_frames(a_sd), .stat_tx_err(a_se)
    );

    gem_ext_fifo_tx_sf #(.ADDR_WIDTH(6), .DROP_BAD_FRAME(0)) dut_b (
        .clk(clk), .rst(rst),
        .s_axis_tdata(tdata), .s_axis_tvalid(tvalid & sel), .s_axis_tlast(tlast),
        .s_axis_tuser(tuser), .s_axis_tready(b_tready),
        .gem_data(b_data), .gem_data_ready(b_ready), .gem_data_valid(b_valid),
        .gem_data_rd_request(rd_req & sel), .gem_sop(b_sop), .gem_eop(b_eop), .gem_err(b_err),
        .gem_underflow(b_uf), .gem_control(b_ctrl), .gem_dma_tx_end_tog(end_tog),
        .gem_status(status), .gem_dma_tx_status_tog(b_stog), .tx_status(b_txs),
        .stat_tx_frames(b_sf), .stat_drop_frames(b_sd), .stat_tx_err(b_se)
    );

    assign o_tready = sel ? b_tready : a_tready;
    assign o_ready  = sel ? b_ready  : a_ready;
    assign o_valid  = sel ? b_valid  : a_valid;
    assign o_sop    = sel ? b_sop    : a_sop;
    assign o_eop    = sel ? b_eop    : a_eop;
    assign o_err    = sel ? b_err    : a_err;
    assign o_uf     = sel ? b_uf     : a_uf;
    assign o_ctrl   = sel ? b_ctrl   : a_ctrl;
    assign o_stog   = sel ? b_stog   : a_stog;
    assign o_data   = sel ? b_data   : a_data;
    assign o_txs    = sel ? b_txs    : a_txs;
    assign o_sf     = sel ? b_sf     : a_sf;
    assign o_sd     = sel ? b_sd     : a_sd;
    assign o_se     = sel ? b_se     : a_se;

    task automatic apply_reset();
        rst = 1'b1; tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0; rd_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_frame(input int len, input int base, input bit user);
        for (int i = 0; i < len; i++) begin
            int t;
            tdata  = 8'(base + i);
            tvalid = 1'b1;
            tlast  = (i == len - 1);
            tuser  = user && (i == len - 1);
            t = 0;
            while (!o_tready && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (t == 200) begin
                vectors++; miscompares++;
                $display("FAIL send_tready byte %0d: tready=0 required 1", i);
            end
            @(negedge clk);
        end
        tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
    endtask

    // Back-to-back requests; nreq < len reads only the head of the frame
    task automatic read_frame(input int len, input int base, input bit err_last, input int nreq);
        logic [12:0] got, exp;
        int bad;
        bad = 0;
        rd_req = 1'b1;
        for (int i = 0; i < nreq; i++) begin
            @(negedge clk);
            if (i == nreq - 1) rd_req = 1'b0;
            exp = {1'b1, 1'b0, (i == 0), (i == len - 1), (err_last && (i == len - 1)), 8'(base + i)};
            got = {o_valid, o_uf, o_sop, o_eop, o_err, o_data};
            vectors++;
            if (got !== exp) begin
                miscompares++; bad++;
                $display("FAIL read_byte %0d {valid,uf,sop,eop,err,data}: got %h required %h", i, got, exp);
            end
        end
        $display("read %0d of %0d bytes base %h on dut_%s, %0d bad", nreq, len, base, sel ? "b" : "a", bad);
    endtask

    task automatic check_ready(input bit exp, input string name);
        vectors++;
        if (o_ready !== exp) begin
            miscompares++;
            $display("FAIL %s: gem_data_ready=%b required %b", name, o_ready, exp);
        end
    endtask

    task automatic test_reset();
        logic [19:0] got;
        apply_reset();
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            got = {o_tready, o_ready, o_valid, o_uf, o_sop, o_eop, o_err, o_ctrl, o_data, o_stog, 3'b000};
            vectors++;
            if (got !== 20'h80000 || o_txs !== 4'h0) begin
                miscompares++;
                $display("FAIL reset_outputs dut %0d: got %h/%h required 80000/0", s, got, o_txs);
            end
            vectors++;
            if (o_sf !== 32'd0 || o_sd !== 32'd0 || o_se !== 32'd0) begin
                miscompares++;
                $display("FAIL reset_stats dut %0d: got %0d/%0d/%0d required 0/0/0", s, o_sf, o_sd, o_se);
            end
        end
        sel = 1'b0;
        $display("reset checked on both instances");
    endtask

    task automatic test_frame64();
        sel = 1'b0;
        check_ready(1'b0, "frame64_ready_before");
        send_frame(64, 8'h00, 1'b0);
        check_ready(1'b1, "frame64_ready_after_tlast");
        read_frame(64, 8'h00, 1'b0, 64);
        @(negedge clk);
        check_ready(1'b0, "frame64_ready_after_eop");
    endtask

    task automatic test_bad_frame();
        sel = 1'b0;
        send_frame(10, 8'hC0, 1'b1);
        @(negedge clk);
        check_ready(1'b0, "bad_frame_not_ready");
`ifdef GEM_TX_STATS_EN
        vectors++;
        if (o_sd !== 32'd1) begin
            miscompares++;
            $display("FAIL bad_frame_drop_count: got %0d required 1", o_sd);
        end
`endif
        send_frame(5, 8'hA0, 1'b0);
        check_ready(1'b1, "good_after_bad_ready");
        read_frame(5, 8'hA0, 1'b0, 5);
        @(negedge clk);
`ifdef GEM_TX_STATS_EN
        vectors++;
        if (o_sf !== 32'd2 || o_sd !== 32'd1) begin
            miscompares++;
            $display("FAIL stats_tx_drop: got %0d/%0d required 2/1", o_sf, o_sd);
        end
`else
        vectors++;
        if (o_sf !== 32'd0 || o_sd !== 32'd0) begin
            miscompares++;
            $display("FAIL stats_tied_off: got %0d/%0d required 0/0", o_sf, o_sd);
        end
`endif
    endtask

    task automatic test_underflow();
        logic [12:0] got;
        sel = 1'b0;
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
        got = {o_valid, o_uf, o_sop, o_eop, o_err, o_data};
        vectors++;
        if (got !== 13'h1800) begin
            miscompares++;
            $display("FAIL underflow {valid,uf,sop,eop,err,data}: got %h required 1800", got);
        end
        @(negedge clk);
        vectors++;
        if (o_valid !== 1'b0 || o_uf !== 1'b0) begin
            miscompares++;
            $display("FAIL underflow_clear: valid=%b uf=%b required 0/0", o_valid, o_uf);
        end
        $display("underflow request served");
    endtask

    task automatic test_status();
        sel = 1'b0;
        status = 4'h2; end_tog = ~end_tog;
        @(negedge clk);
        vectors++;
        if (o_txs !== 4'h2 || o_stog !== 1'b0) begin
            miscompares++;
            $display("FAIL status_capture: tx_status=%h tog=%b required 2/0", o_txs, o_stog);
        end
        @(negedge clk);
        vectors++;
        if (o_stog !== 1'b1) begin
            miscompares++;
            $display("FAIL status_tog_flip: got %b required 1", o_stog);
        end
`ifdef GEM_TX_STATS_EN
        vectors++;
        if (o_se !== 32'd1) begin
            miscompares++;
            $display("FAIL stat_tx_err: got %0d required 1", o_se);
        end
`endif
        status = 4'h0; end_tog = ~end_tog;
        repeat (2) @(negedge clk);
        vectors++;
        if (o_txs !== 4'h0 || o_stog !== 1'b0) begin
            miscompares++;
            $display("FAIL status_second_edge: tx_status=%h tog=%b required 0/0", o_txs, o_stog);
        end
`ifdef GEM_TX_STATS_EN
        vectors++;
        if (o_se !== 32'd1) begin
            miscompares++;
            $display("FAIL stat_tx_err_ok_status: got %0d required 1", o_se);
        end
`endif
        $display("status handshake done, tx_status=%h", o_txs);
    endtask

    // Second frame's commit lands in the same cycle as the first frame's eop
    task automatic test_back_to_back();
        sel = 1'b0;
        send_frame(8, 8'h10, 1'b0);
        fork
            send_frame(9, 8'h60, 1'b0);
            read_frame(8, 8'h10, 1'b0, 8);
        join
        check_ready(1'b1, "commit_eop_same_cycle_ready");
        read_frame(9, 8'h60, 1'b0, 9);
        @(negedge clk);
        check_ready(1'b0, "back_to_back_drained");
    endtask

    task automatic test_reset_mid_read();
        sel = 1'b0;
        send_frame(6, 8'h20, 1'b0);
        send_frame(6, 8'h30, 1'b0);
        send_frame(6, 8'h40, 1'b0);
        read_frame(6, 8'h20, 1'b0, 3);
        apply_reset();
        check_ready(1'b0, "mid_read_reset_ready");
`ifdef GEM_TX_STATS_EN
        vectors++;
        if (o_sf !== 32'd0 || o_se !== 32'd0) begin
            miscompares++;
            $display("FAIL stats_after_reset: got %0d/%0d required 0/0", o_sf, o_se);
        end
`endif
        send_frame(4, 8'h70, 1'b0);
        read_frame(4, 8'h70, 1'b0, 4);
    endtask

    task automatic test_err_forward();
        sel = 1'b1;
        send_frame(4, 8'h50, 1'b1);
        check_ready(1'b1, "err_forward_ready");
        read_frame(4, 8'h50, 1'b1, 4);
    endtask

    task automatic test_overflow();
        sel = 1'b1;
        send_frame(70, 8'h00, 1'b0);
        @(negedge clk);
        check_ready(1'b0, "overflow_frame_dropped");
`ifdef GEM_TX_STATS_EN
        vectors++;
        if (o_sd !== 32'd1) begin
            miscompares++;
            $display("FAIL overflow_drop_count: got %0d required 1", o_sd);
        end
`endif
        send_frame(10, 8'h90, 1'b0);
        check_ready(1'b1, "after_overflow_ready");
        read_frame(10, 8'h90, 1'b0, 10);
    endtask

    task automatic test_saturation();
        sel = 1'b1;
        for (int i = 0; i < 63; i++) send_frame(1, i, 1'b0);
        vectors++;
        if (o_tready !== 1'b0) begin
            miscompares++;
            $display("FAIL saturation_tready: got %b required 0", o_tready);
        end
        read_frame(1, 8'h00, 1'b0, 1);
        @(negedge clk);
        vectors++;
        if (o_tready !== 1'b1) begin
            miscompares++;
            $display("FAIL saturation_release: tready=%b required 1", o_tready);
        end
        read_frame(1, 8'h01, 1'b0, 1);
    endtask

    initial begin
        sel = 1'b0; tdata = 8'h00; end_tog = 1'b0; status = 4'h0;
        test_reset();
        test_frame64();
        test_bad_frame();
        test_underflow();
        test_status();
        test_back_to_back();
        test_reset_mid_read();
        test_err_forward();
        test_overflow();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
